kbd_scan_ctrl: RTL and testbench
================================

KBD_SCAN_CTRL -- requirements
Module: kbd_scan_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1000: cycles BREAK_WAIT may wait for the byte after F0 before abandoning the break.
REQ-002 Parameter CNT_W, default 8: width of the key press counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ps2_data  input  8  received scan-code byte.
REQ-006 ps2_valid  input  1  ps2_data holds a new byte.
REQ-007 ps2_ready  output  1  block can accept a byte; transfer when ps2_valid && ps2_ready.
REQ-008 code_out  output  8  make scan code posted to the ASCII lookup/display path.
REQ-009 code_valid  output  1  code_out holds a posted make event.
REQ-010 code_ready  input  1  downstream accepts; event consumed when code_valid && code_ready.
REQ-011 key_code  output  8  scan code of the currently held key; 8'h00 when none.
REQ-012 key_active  output  1  a key is held; display enable (blank when 0).
REQ-013 key_ext  output  1  held key was preceded by E0 prefix.
REQ-014 key_cnt  output  CNT_W  count of distinct make events accepted.

Function
REQ-015 FSM states: IDLE, PRESSED, BREAK_WAIT; flag ext_pend records a pending E0 prefix.
REQ-016 Bytes 8'h00 are accepted and ignored in every state, with no state change.
REQ-017 Byte 8'hE0 in IDLE or PRESSED sets ext_pend and leaves the state unchanged.
REQ-018 IDLE, byte B (not 00/E0/F0): key_code=B, key_ext=ext_pend, ext_pend=0, key_active=1, key_cnt+1, post make event, go to PRESSED.
REQ-019 IDLE, byte F0: go to BREAK_WAIT (stray break), ext_pend cleared.
REQ-020 PRESSED, byte equal to key_code: typematic repeat; no count, no event, ext_pend cleared.
REQ-021 PRESSED, different byte B (not 00/E0/F0): rollover; key_code=B, key_ext=ext_pend, key_cnt+1, post make event.
REQ-022 PRESSED, byte F0: go to BREAK_WAIT; ext_pend cleared.
REQ-023 BREAK_WAIT, byte equal to key_code while key_active: release; key_code=00, key_active=0, key_ext=0, go to IDLE.
REQ-024 BREAK_WAIT, any other byte (incl. E0): break of non-held key, discarded; go to PRESSED if key_active else IDLE.
REQ-025 BREAK_WAIT timer counts cycles since entry; at TIMEOUT cycles with no byte, return as in REQ-024.
REQ-026 Posting a make event: code_out=B, code_valid=1 on the cycle after the accepting edge; code_valid holds with code_out stable until code_ready.
REQ-027 ps2_ready = !(code_valid && !code_ready); no byte is accepted while a posted event is stalled.
REQ-028 Event accept and new byte accept on the same edge are legal; the new event overwrites code_out and code_valid stays 1.
REQ-029 key_cnt wraps modulo 2^CNT_W with no saturation or flag.
REQ-030 All outputs are registered except ps2_ready.

Reset
REQ-031 On rst_n low, at any time: state=IDLE, ext_pend=0, timer=0, key_code=00, key_active=0, key_ext=0, key_cnt=0, code_out=00, code_valid=0; ps2_ready=1 after release.
REQ-032 Reset mid-BREAK_WAIT or while code_valid is stalled drops the pending event.

Verification
REQ-033 Bytes 1C, 1C, 1C, F0, 1C with code_ready=1 -> one event code_out=1C, key_cnt=1, key_active=0 at end.
REQ-034 Bytes E0, 75, F0, 75 -> key_ext=1 while held, key_code=75, then key_code=00, key_ext=0.
REQ-035 code_ready=0, bytes 1C then 32 offered -> 32 stalled (ps2_ready=0) until code_ready=1; then code_out=32, key_cnt=2.
REQ-036 Bytes 1C, F0, then idle TIMEOUT cycles -> back in PRESSED, key_code=1C; byte F0, 32 -> no release, key_code=1C.
REQ-037 CNT_W=8, 256 alternating makes 1C/32 -> key_cnt returns to 0.
REQ-038 rst_n low during BREAK_WAIT with code_valid=1 -> all outputs at REQ-031 values asynchronously.

Source files
------------

// File: rtl/kbd_scan_ctrl.sv
// PS/2 keyboard scan-code controller: tracks the held key (with E0 extension),
// counts make events and posts each make code downstream over a valid/ready link.
module kbd_scan_ctrl #(
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_valid,
  output logic             ps2_ready,
  output logic [7:0]       code_out,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [7:0]       key_code,
  output logic             key_active,
  output logic             key_ext,
  output logic [CNT_W-1:0] key_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_BREAK   = 2'd2;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [7:0] B_NULL = 8'h00;
  localparam logic [7:0] B_EXT  = 8'hE0;
  localparam logic [7:0] B_BRK  = 8'hF0;

  logic [1:0]       r_state;
  logic             r_ext_pend;
  logic [TW-1:0]    r_timer;
  logic [7:0]       r_key_code;
  logic             r_key_active;
  logic             r_key_ext;
  logic [CNT_W-1:0] r_key_cnt;
  logic [7:0]       r_code_out;
  logic             r_code_valid;

  logic       w_accept;
  logic       w_byte;
  logic [1:0] w_nstate;
  logic       w_npend;
  logic       w_post;
  logic       w_release;

  // A stalled posted event blocks intake; the downstream ready feeds through
  // so a consume and a new accept can share one edge.
  assign ps2_ready = !(r_code_valid && !code_ready);
  assign w_accept  = ps2_valid && ps2_ready;
  assign w_byte    = w_accept && (ps2_data != B_NULL);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_nstate  = r_state;
    w_npend   = r_ext_pend;
    w_post    = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE, S_PRESSED: begin
        if (w_byte) begin
          if (ps2_data == B_EXT) begin
            w_npend = 1'b1;
          end else if (ps2_data == B_BRK) begin
            w_nstate = S_BREAK;
            w_npend  = 1'b0;
          end else if (r_state == S_PRESSED && ps2_data == r_key_code) begin
            w_npend = 1'b0;
          end else begin
            w_post   = 1'b1;
            w_npend  = 1'b0;
            w_nstate = S_PRESSED;
          end
        end
      end
      S_BREAK: begin
        if (w_byte) begin
          if (r_key_active && ps2_data == r_key_code) begin
            w_release = 1'b1;
            w_nstate  = S_IDLE;
          end else begin
            w_nstate = r_key_active ? S_PRESSED : S_IDLE;
          end
        end else if (r_timer == TIMER_LAST) begin
          w_nstate = r_key_active ? S_PRESSED : S_IDLE;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ext_pend   <= 1'b0;
      r_timer      <= '0;
      r_key_code   <= B_NULL;
      r_key_active <= 1'b0;
      r_key_ext    <= 1'b0;
      r_key_cnt    <= '0;
      r_code_out   <= B_NULL;
      r_code_valid <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_ext_pend <= w_npend;
      r_timer    <= (r_state == S_BREAK && w_nstate == S_BREAK) ? r_timer + TW'(1) : '0;

      if (w_post) begin
        r_key_code   <= ps2_data;
        r_key_ext    <= r_ext_pend;
        r_key_active <= 1'b1;
        r_key_cnt    <= r_key_cnt + CNT_W'(1);
      end else if (w_release) begin
        r_key_code   <= B_NULL;
        r_key_ext    <= 1'b0;
        r_key_active <= 1'b0;
      end

      if (w_post) begin
        r_code_out   <= ps2_data;
        r_code_valid <= 1'b1;
      end else if (code_ready) begin
        r_code_valid <= 1'b0;
      end
    end
  end

  assign code_out   = r_code_out;
  assign code_valid = r_code_valid;
  assign key_code   = r_key_code;
  assign key_active = r_key_active;
  assign key_ext    = r_key_ext;
  assign key_cnt    = r_key_cnt;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Bench for kbd_scan_ctrl: directed scenarios plus random byte traffic, all
// outputs compared every cycle against a behavioural key-tracking model.
module tb_kbd_scan_ctrl;

  localparam int TO = 20;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    ps2_data = 8'h00;
  logic          ps2_valid = 1'b0;
  logic          ps2_ready;
  logic [7:0]    code_out;
  logic          code_valid;
  logic          code_ready = 1'b0;
  logic [7:0]    key_code;
  logic          key_active;
  logic          key_ext;
  logic [CW-1:0] key_cnt;

  kbd_scan_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_data  (ps2_data),
    .ps2_valid (ps2_valid),
    .ps2_ready (ps2_ready),
    .code_out  (code_out),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .key_code  (key_code),
    .key_active(key_active),
    .key_ext   (key_ext),
    .key_cnt   (key_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int ev_cnt  = 0;

  // Reference model: what the keyboard is doing, not how the RTL encodes it.
  logic [7:0]    m_key;
  logic          m_active, m_ext, m_pend, m_in_break, m_cv;
  logic [7:0]    m_out;
  logic [CW-1:0] m_cnt;
  int            m_wait;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_key = 8'h00; m_active = 0; m_ext = 0; m_pend = 0; m_in_break = 0;
    m_cv = 0; m_out = 8'h00; m_cnt = '0; m_wait = 0;
  endtask

  task automatic model_edge(input logic acc, input logic [7:0] b, input logic cr);
    logic post;
    post = 0;
    if (acc && b != 8'h00) begin
      if (m_in_break) begin
        m_in_break = 0;
        if (m_active && b == m_key) begin
          m_key = 8'h00; m_active = 0; m_ext = 0;
        end
      end else if (b == 8'hE0) begin
        m_pend = 1;
      end else if (b == 8'hF0) begin
        m_in_break = 1; m_wait = 0; m_pend = 0;
      end else if (m_active && b == m_key) begin
        m_pend = 0;
      end else begin
        m_key = b; m_ext = m_pend; m_pend = 0; m_active = 1;
        m_cnt = m_cnt + 1'b1; post = 1;
      end
    end else if (m_in_break) begin
      m_wait++;
      if (m_wait == TO) m_in_break = 0;
    end
    if (post) begin
      m_out = b; m_cv = 1;
    end else if (cr) begin
      m_cv = 0;
    end
  endtask

  task automatic check_outputs();
    check("code_valid", code_valid, m_cv);
    check("code_out",   code_out,   m_out);
    check("key_code",   key_code,   m_key);
    check("key_active", key_active, m_active);
    check("key_ext",    key_ext,    m_ext);
    check("key_cnt",    key_cnt,    m_cnt);
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic cr, output logic acc);
    logic exp_ready;
    ps2_valid = v; ps2_data = d; code_ready = cr;
    #1;
    exp_ready = !(m_cv && !cr);
    check("ps2_ready", ps2_ready, exp_ready);
    acc = v && exp_ready;
    if (code_valid && cr) ev_cnt++;
    @(posedge clk);
    model_edge(acc, d, cr);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic cr);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, cr, acc);
  endtask

  task automatic send(input logic [7:0] d, input logic cr);
    logic acc;
    acc = 0;
    for (int i = 0; i < 40 && !acc; i++) step(1'b1, d, cr, acc);
    check("send_accepted", acc, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_key_code"},   key_code,   8'h00);
    check({tag, "_key_active"}, key_active, 1'b0);
    check({tag, "_key_ext"},    key_ext,    1'b0);
    check({tag, "_key_cnt"},    key_cnt,    '0);
    check({tag, "_code_out"},   code_out,   8'h00);
    check({tag, "_code_valid"}, code_valid, 1'b0);
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    ps2_valid = 1'b0; code_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check({tag, "_ready_after"}, ps2_ready, 1'b1);
  endtask

  initial begin
    logic acc;
    logic have_byte;
    logic [7:0] cur_byte;
    logic [7:0] pool [8];
    model_reset();

    // Power-on reset
    @(negedge clk);
    @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    #1;
    check("por_ready", ps2_ready, 1'b1);
    @(negedge clk);

    // Typematic repeats then release: single event
    ev_cnt = 0;
    send(8'h1C, 1); send(8'h1C, 1); send(8'h1C, 1);
    send(8'hF0, 1); send(8'h1C, 1);
    idle(2, 1);
    check("t33_events", ev_cnt, 1);
    check("t33_code_out", code_out, 8'h1C);
    check("t33_cnt", key_cnt, 1);
    check("t33_active", key_active, 1'b0);

    // Extended key held then released
    mid_reset("r34");
    send(8'hE0, 1); send(8'h75, 1);
    check("t34_ext_held", key_ext, 1'b1);
    check("t34_code_held", key_code, 8'h75);
    send(8'hF0, 1); send(8'h75, 1);
    check("t34_code_rel", key_code, 8'h00);
    check("t34_ext_rel", key_ext, 1'b0);

    // Stalled event blocks the next byte until downstream is ready
    mid_reset("r35");
    send(8'h1C, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h32, 1'b0, acc);
    check("t35_stall_ready", ps2_ready, 1'b0);
    check("t35_stall_cnt", key_cnt, 1);
    step(1'b1, 8'h32, 1'b1, acc);
    check("t35_code_out", code_out, 8'h32);
    check("t35_valid", code_valid, 1'b1);
    check("t35_cnt", key_cnt, 2);
    idle(1, 1);

    // Break timeout: last byte inside the window releases, at the limit it does not
    mid_reset("r36");
    send(8'h1C, 1); send(8'hF0, 1);
    idle(TO, 1);
    check("t36_code", key_code, 8'h1C);
    check("t36_active", key_active, 1'b1);
    send(8'hF0, 1); send(8'h32, 1);
    check("t36_norel_code", key_code, 8'h1C);
    check("t36_norel_active", key_active, 1'b1);
    send(8'hF0, 1); idle(TO, 1); send(8'h1C, 1);
    check("t36_limit_held", key_active, 1'b1);
    send(8'hF0, 1); idle(TO - 1, 1); send(8'h1C, 1);
    check("t36_window_rel", key_active, 1'b0);

    // Reset while waiting for a break byte with a key held
    send(8'h32, 1); send(8'hF0, 1);
    mid_reset("r38a");
    // Reset while a posted event is stalled
    send(8'h75, 0);
    check("t38_stalled", code_valid, 1'b1);
    mid_reset("r38b");

    // Counter wraps after 256 makes
    for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 8'h1C : 8'h32, 1);
    check("t37_wrap", key_cnt, 0);
    check("t37_last", key_code, 8'h32);

    // Random traffic; bytes are held until accepted
    pool[0] = 8'h00; pool[1] = 8'hE0; pool[2] = 8'hF0; pool[3] = 8'h1C;
    pool[4] = 8'h32; pool[5] = 8'h75; pool[6] = 8'h1C; pool[7] = 8'hF0;
    have_byte = 0;
    cur_byte  = 8'h00;
    for (int n = 0; n < 1500; n++) begin
      if (!have_byte && $urandom_range(0, 39) == 0) begin
        idle($urandom_range(TO - 2, TO + 2), $urandom_range(0, 3) != 0);
      end else begin
        if (!have_byte && $urandom_range(0, 9) < 6) begin
          have_byte = 1;
          cur_byte  = pool[$urandom_range(0, 7)];
        end
        step(have_byte, cur_byte, $urandom_range(0, 9) < 7, acc);
        if (acc) have_byte = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
